// File: rtl/int_pkg.sv
// Shared types and defaults for the interrupt controller.
//   INT_STATES : controller FSM states
//   N_SRC_DEF  : default number of interrupt sources
//   ID_W_DEF   : default source-ID width, $clog2(N_SRC_DEF)
package int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } INT_STATES;

    localparam int unsigned N_SRC_DEF = 8;
    localparam int unsigned ID_W_DEF  = 3;

endpackage

// File: rtl/int_controller_if.sv
// Handshake and mask-write bus between the control unit and the interrupt controller.
//   I_SET, I_CLR     : SEI / CLI strobes from the control unit
//   INT_ACK          : control unit entered its interrupt state
//   INT_DONE         : RETIE/RETID, service finished
//   MASK_WE/MASK_DATA: mask register write from the OUT port path
//   INT_R, INT_ID    : interrupt request and source index to the control unit
//   IE               : global enable, mirrored into the control unit's I flag
interface int_controller_if #(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = 3
) ();

    logic             I_SET;
    logic             I_CLR;
    logic             INT_ACK;
    logic             INT_DONE;
    logic             MASK_WE;
    logic [N_SRC-1:0] MASK_DATA;
    logic             INT_R;
    logic [ID_W-1:0]  INT_ID;
    logic             IE;

    // Control unit side
    modport master (
        output I_SET, I_CLR, INT_ACK, INT_DONE, MASK_WE, MASK_DATA,
        input  INT_R, INT_ID, IE
    );

    // Interrupt controller side
    modport slave (
        input  I_SET, I_CLR, INT_ACK, INT_DONE, MASK_WE, MASK_DATA,
        output INT_R, INT_ID, IE
    );

endinterface

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins.
//   req   : request vector
//   valid : any bit of req set
//   idx   : index of the lowest set bit (0 when none)
module int_prio_enc #(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = 3
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Prioritized interrupt controller.
//   CLK, RESET : system clock, synchronous active-high reset
//   IRQ_IN     : peripheral request lines; each rising edge is one event
//   OVR        : sticky overrun, cleared by a mask write
//   cu         : control-unit handshake and mask-write bus (slave side)
// Events latch into pend regardless of the mask; pend & mask selects the
// lowest-index winner, which is presented on INT_R/INT_ID and held frozen
// until acknowledged.
module int_controller
    import int_pkg::*;
#(
    parameter int unsigned N_SRC = N_SRC_DEF,
    parameter int unsigned ID_W  = ID_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ_IN,
    output logic             OVR,
    int_controller_if.slave  cu
);

    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q;
    logic             ie_q, ie_d;
    logic             ovr_q, ovr_d;
    logic [ID_W-1:0]  int_id_q, int_id_d;
    logic             int_r_q;
    INT_STATES        state_q, state_d;

    logic [N_SRC-1:0] irq_edge;
    logic [N_SRC-1:0] clr_vec;
    logic             ack_ok;
    logic             win_valid;
    logic [ID_W-1:0]  win_id;

    int_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio (
        .req   (pend_q & mask_q),
        .valid (win_valid),
        .idx   (win_id)
    );

    // Pending, overrun and enable bookkeeping
    always_comb begin
        irq_edge = IRQ_IN & ~irq_q;
        ack_ok   = (state_q == ST_REQ) && cu.INT_ACK;
        clr_vec  = ack_ok ? (N_SRC'(1) << int_id_q) : '0;
        // A new edge beats the ack clear on the same bit.
        pend_d   = (pend_q & ~clr_vec) | irq_edge;
        // Overrun only when the bit stays pending; a fresh overrun beats the clear.
        ovr_d    = (ovr_q & ~cu.MASK_WE) | (|(irq_edge & pend_q & ~clr_vec));
        if (cu.I_CLR || ack_ok) begin
            ie_d = 1'b0;
        end else if (cu.I_SET) begin
            ie_d = 1'b1;
        end else begin
            ie_d = ie_q;
        end
    end

    // FSM next state
    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ie_q && win_valid) begin
                    state_d  = ST_REQ;
                    int_id_d = win_id;
                end
            end
            ST_REQ: begin
                if (cu.INT_ACK) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (cu.INT_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            irq_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            ie_q     <= 1'b0;
            ovr_q    <= 1'b0;
            int_id_q <= '0;
            int_r_q  <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            irq_q    <= IRQ_IN;
            pend_q   <= pend_d;
            ie_q     <= ie_d;
            ovr_q    <= ovr_d;
            int_id_q <= int_id_d;
            int_r_q  <= (state_d == ST_REQ);
            state_q  <= state_d;
            if (cu.MASK_WE) begin
                mask_q <= cu.MASK_DATA;
            end
        end
    end

    assign cu.INT_R  = int_r_q;
    assign cu.INT_ID = int_id_q;
    assign cu.IE     = ie_q;
    assign OVR       = ovr_q;

endmodule
